instr_prefetch_buffer: RTL

//  Instruction prefetch queue between the instruction-memory port and the fetch stage.

---
 rtl/instr_prefetch_buffer_pkg.sv | 19 +
 rtl/instr_prefetch_buffer_if.sv | 23 ++
 rtl/instr_prefetch_buffer_sync_fifo.sv | 52 +++++
 rtl/instr_prefetch_buffer.sv | 103 ++++++++++
 4 files changed

// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package instr_prefetch_buffer_pkg;

    localparam int XLEN = 64;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Instruction-memory request/response bus (req/gnt/rvalid).
interface instr_prefetch_buffer_if;
    import instr_prefetch_buffer_pkg::*;

    logic               mem_req_o;
    logic [XLEN-1:0]    mem_addr_o;
    logic               mem_gnt_i;
    logic               mem_rvalid_i;
    logic [INSTR_W-1:0] mem_rdata_i;

    // Prefetcher side issues requests and receives responses.
    modport master (
        output mem_req_o, mem_addr_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    // Memory side accepts requests and returns responses in order.
    modport slave (
        input  mem_req_o, mem_addr_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/instr_prefetch_buffer_sync_fifo.sv
// Generic synchronous FIFO with flush; depth need not be a power of two.
module instr_prefetch_buffer_sync_fifo #(
    parameter type T = logic [31:0],
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count
);

    T              mem_q [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          pop_eff, push_eff;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Popping an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
    assign pop_eff  = pop & (count != '0);
    assign push_eff = push & ((int'(count) < DEPTH) | pop_eff);
    assign head     = mem_q[rd_ptr];

    // Storage, pointers and occupancy; clear empties the FIFO and wins over push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                mem_q[wr_ptr] <= push_data;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (pop_eff) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push_eff) - CW'(pop_eff);
        end
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch queue: issues sequential word fetches, buffers responses
// with their PCs and flushes everything (including in-flight data) on redirect.
module instr_prefetch_buffer
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MAX_OUT = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    input  logic                stall_i,
    output logic                instr_valid_o,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [XLEN-1:0]     pc_o,
    instr_prefetch_buffer_if.master mem
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic            run;
    logic [XLEN-1:0] fetch_pc, tag_pc;
    logic [OW-1:0]   outstanding, drop_cnt, tag_count;
    logic [CW-1:0]   count;
    logic            accept, rvalid, dropping, keep, pop, credit;
    fetch_entry_t    head, push_entry;

    assign rvalid   = mem.mem_rvalid_i;
    assign accept   = mem.mem_req_o & mem.mem_gnt_i;
    assign dropping = (drop_cnt != '0);
    // A response is kept only if it belongs to the current fetch stream.
    assign keep     = rvalid & ~dropping & ~redirect_i;
    assign pop      = instr_valid_o & ~stall_i;

    // Every buffered or in-flight word holds a FIFO slot, so the FIFO never overflows.
    assign credit         = (int'(count) + int'(outstanding) < DEPTH) & (int'(outstanding) < MAX_OUT);
    // run holds requests off until the first cycle after reset release.
    assign mem.mem_req_o  = run & ~redirect_i & credit;
    assign mem.mem_addr_o = fetch_pc;

    assign push_entry.pc    = tag_pc;
    assign push_entry.instr = mem.mem_rdata_i;

    assign instr_valid_o = (count != '0);
    assign instr_o       = head.instr;
    assign pc_o          = head.pc;

    // Fetch address, in-flight and to-be-discarded response counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding + OW'(accept) - OW'(rvalid);
            if (redirect_i) begin
                fetch_pc <= word_align(redirect_pc_i);
                // A response arriving in the redirect cycle is discarded right now.
                drop_cnt <= outstanding - OW'(rvalid);
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                if (rvalid && dropping) drop_cnt <= drop_cnt - OW'(1);
            end
        end
    end

    // PCs of live requests; on redirect all of them become drops and are forgotten.
    instr_prefetch_buffer_sync_fifo #(.T(logic [XLEN-1:0]), .DEPTH(MAX_OUT)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_i),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (keep),
        .head      (tag_pc),
        .count     (tag_count)
    );

    instr_prefetch_buffer_sync_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_i),
        .push      (keep),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // The memory may only answer requests it has accepted.
    a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!rst)
        !(rvalid && outstanding == '0));

    // Every in-flight request is either tagged for the FIFO or counted as a drop.
    a_tag_accounting: assert property (@(posedge clk) disable iff (!rst)
        int'(tag_count) + int'(drop_cnt) == int'(outstanding));

endmodule
